// File: rtl/sort_seq_ctrl.sv
// Frame sorter: loads N words, selection-style compare-exchange sort in place, drains ascending.
// Latency: out_valid rises N(N-1)/2 edges after the last input word is accepted.
// Backpressure: in_ready only in LOAD; DRAIN holds out_data/out_last while out_ready is low.
module sort_seq_ctrl #(
    parameter int W = 8,
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [KW-1:0] K_PEN  = KW'(N - 2);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [KW-1:0]   i_q, i_d;
    logic [KW-1:0]   j_q, j_d;
    logic [W-1:0]    mem_q [N];
    logic [W-1:0]    mem_d [N];

    // State register, counters and storage; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD;
            k_q     <= '0;
            i_q     <= K_LAST;
            j_q     <= K_PEN;
            for (int m = 0; m < N; m++) begin
                mem_q[m] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
            j_q     <= j_d;
            for (int m = 0; m < N; m++) begin
                mem_q[m] <= mem_d[m];
            end
        end
    end

    // Next-state: load words, walk compare pairs (i,j) once each, then drain by k.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        i_d     = i_q;
        j_d     = j_q;
        for (int m = 0; m < N; m++) begin
            mem_d[m] = mem_q[m];
        end
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    mem_d[k_q] = in_data;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        i_d     = K_LAST;
                        j_d     = K_PEN;
                        state_d = SORT;
                    end else begin
                        k_d = k_q + K_ONE;
                    end
                end
            end
            SORT: begin
                // Strictly-greater test keeps equal values in place.
                if (mem_q[j_q] > mem_q[i_q]) begin
                    mem_d[i_q] = mem_q[j_q];
                    mem_d[j_q] = mem_q[i_q];
                end
                if (j_q == '0) begin
                    if (i_q == K_ONE) begin
                        state_d = DRAIN;
                        k_d     = '0;
                        i_d     = K_LAST;
                        j_d     = K_PEN;
                    end else begin
                        i_d = i_q - K_ONE;
                        j_d = i_d - K_ONE;
                    end
                end else begin
                    j_d = j_q - K_ONE;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = LOAD;
                    end else begin
                        k_d = k_q + K_ONE;
                    end
                end
            end
            default: begin
                state_d = LOAD;
                k_d     = '0;
            end
        endcase
    end

    // Outputs decode directly from registered state, so they are stable under stall.
    always_comb begin
        in_ready  = (state_q == LOAD);
        busy      = (state_q != LOAD);
        out_valid = (state_q == DRAIN);
        out_last  = (state_q == DRAIN) && (k_q == K_LAST);
        out_data  = (state_q == DRAIN) ? mem_q[k_q] : '0;
    end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Directed bench for sort_seq_ctrl (W=8, N=5): frame loading, sort latency, draining with stalls,
// input masking outside LOAD, mid-sort reset and back-to-back frames.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_sort_seq_ctrl;

    typedef logic [7:0] frame_t [5];

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int passes;
    int total;

    sort_seq_ctrl #(.W(8), .N(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present five words; gap idle cycles between words; hold = in_valid level after the frame.
    task automatic send_frame(input frame_t w, input int gap, input logic hold);
        for (int n = 0; n < 5; n++) begin
            in_valid = 1'b1;
            in_data  = w[n];
            chk($sformatf("in_ready_load%0d", n), 32'(in_ready), 32'd1);
            tick();
            if (gap > 0 && n < 4) begin
                in_valid = 1'b0;
                in_data  = 8'h5A;
                repeat (gap) tick();
            end
        end
        in_valid = hold;
        in_data  = 8'hAA;
    endtask

    // Count edges from the last accept until out_valid; expect exactly 10.
    task automatic wait_out(input logic hold);
        int n;
        n = 0;
        chk("busy_sort", 32'(busy), 32'd1);
        while (!out_valid && n < 40) begin
            if (hold && n == 4) chk("in_ready_sort", 32'(in_ready), 32'd0);
            tick();
            n++;
        end
        chk("sort_latency", 32'(n), 32'd10);
    endtask

    // Drain five words; stall 3 cycles before handshaking word index stall_at (-1 for none).
    task automatic drain(input frame_t e, input int stall_at, input logic hold);
        for (int n = 0; n < 5; n++) begin
            if (n == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    chk($sformatf("stall_data%0d", s), 32'(out_data), 32'(e[n]));
                    chk($sformatf("stall_valid%0d", s), 32'(out_valid), 32'd1);
                    tick();
                end
                out_ready = 1'b1;
            end
            chk($sformatf("out_data%0d", n), 32'(out_data), 32'(e[n]));
            chk($sformatf("out_last%0d", n), 32'(out_last), (n == 4) ? 32'd1 : 32'd0);
            if (hold) chk($sformatf("in_ready_drain%0d", n), 32'(in_ready), 32'd0);
            tick();
        end
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_last", 32'(out_last), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        frame_t f, e;
        int vcount;
        passes    = 0;
        total     = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;

        // Reset state
        repeat (2) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;

        // Basic frame with duplicate values
        f = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5};
        e = '{8'd1, 8'd1, 8'd3, 8'd4, 8'd5};
        send_frame(f, 0, 1'b0);
        wait_out(1'b0);
        drain(e, -1, 1'b0);

        // All-equal frame then extremes, back to back
        f = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
        send_frame(f, 0, 1'b0);
        wait_out(1'b0);
        drain(f, -1, 1'b0);
        f = '{8'hFF, 8'h00, 8'h80, 8'h01, 8'hFE};
        e = '{8'h00, 8'h01, 8'h80, 8'hFE, 8'hFF};
        send_frame(f, 0, 1'b0);
        wait_out(1'b0);
        drain(e, -1, 1'b0);

        // Output stall on the second word
        f = '{8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        e = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
        send_frame(f, 0, 1'b0);
        wait_out(1'b0);
        drain(e, 1, 1'b0);

        // Gapped input, in_valid held high during SORT/DRAIN
        f = '{8'd2, 8'd9, 8'd0, 8'd9, 8'd4};
        e = '{8'd0, 8'd2, 8'd4, 8'd9, 8'd9};
        send_frame(f, 2, 1'b1);
        wait_out(1'b1);
        drain(e, -1, 1'b1);
        in_valid = 1'b0;

        // Reset during the 4th SORT cycle
        f = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55};
        send_frame(f, 0, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out_data", 32'(out_data), 32'd0);
        chk("abort_out_last", 32'(out_last), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b1;
        vcount = 0;
        for (int n = 0; n < 15; n++) begin
            if (out_valid) vcount++;
            tick();
        end
        chk("abort_no_words", 32'(vcount), 32'd0);
        f = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5};
        e = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        send_frame(f, 0, 1'b0);
        wait_out(1'b0);
        drain(e, -1, 1'b0);

        // Back-to-back frames with no idle cycle between them
        f = '{8'd100, 8'd3, 8'd77, 8'd3, 8'd0};
        e = '{8'd0, 8'd3, 8'd3, 8'd77, 8'd100};
        send_frame(f, 0, 1'b0);
        wait_out(1'b0);
        drain(e, -1, 1'b0);
        f = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        send_frame(f, 0, 1'b0);
        wait_out(1'b0);
        drain(f, -1, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
